cacheline_burst_adaptor: RTL

CACHELINE_BURST_ADAPTOR -- requirements
Module: cacheline_burst_adaptor

---
 rtl/rv32i_types.sv | 15 +
 rtl/cacheline_burst_adaptor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared types and constants for the cacheline burst adaptor.
package rv32i_types;

   localparam int CLA_BEATS   = 4;
   localparam int CLA_BURST_W = 64;
   localparam int CLA_LINE_W  = 256;

   typedef enum logic [1:0] {
      CLA_IDLE = 2'd0,
      CLA_RD   = 2'd1,
      CLA_WR   = 2'd2,
      CLA_DONE = 2'd3
   } cla_state_t;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Converts single 256-bit cacheline requests into 4-beat 64-bit memory bursts.
// Optional beat timeout enabled by defining CACHELINE_BURST_ADAPTOR_TIMEOUT_EN.
module cacheline_burst_adaptor
   import rv32i_types::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CLA_LINE_W-1:0]  line_i,
   input  logic [31:0]            address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic [CLA_LINE_W-1:0]  line_o,
   output logic                   resp_o,
   input  logic [CLA_BURST_W-1:0] burst_i,
   input  logic                   resp_i,
   output logic [CLA_BURST_W-1:0] burst_o,
   output logic [31:0]            address_o,
   output logic                   read_o,
   output logic                   write_o,
   output logic                   err_o,
   output cla_state_t             state_dbg
);

   // Memory handshake: in RD/WR a beat completes on any cycle with resp_i=1;
   // resp_i is ignored in IDLE and DONE, and gaps between beats are allowed.

   cla_state_t              state_q, state_d;
   logic [1:0]              cnt;
   logic [7:0]              beat_lsb;
   logic [31:0]             addr_q;
   logic [CLA_LINE_W-1:0]   wr_line;
   logic [CLA_LINE_W-1:0]   rd_line;
   logic                    in_burst;
   logic                    timeout_hit;

   assign beat_lsb = {cnt, 6'd0};
   assign in_burst = (state_q == CLA_RD) || (state_q == CLA_WR);

`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt;
   logic            err_q;
   logic            unused_ok;

   assign timeout_hit = in_burst && !resp_i && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign err_o       = err_q;
   assign unused_ok   = ^address_i[4:0];

   // Counts consecutive idle beat cycles; any accepted beat restarts the window.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= timeout_hit;
         if (in_burst && !resp_i && !timeout_hit) to_cnt <= to_cnt + 1'b1;
         else                                     to_cnt <= '0;
      end
   end
`else
   logic unused_ok;

   assign timeout_hit = 1'b0;
   assign err_o       = 1'b0;
   assign unused_ok   = ^{address_i[4:0], TIMEOUT_CYCLES};
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= CLA_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLA_IDLE: begin
            if (write_i)     state_d = CLA_WR;
            else if (read_i) state_d = CLA_RD;
         end
         CLA_RD, CLA_WR: begin
            if (resp_i && (cnt == 2'd3)) state_d = CLA_DONE;
            else if (timeout_hit)        state_d = CLA_IDLE;
         end
         CLA_DONE: state_d = CLA_IDLE;
         default:  state_d = CLA_IDLE;
      endcase
   end

   always_comb begin
      read_o    = (state_q == CLA_RD);
      write_o   = (state_q == CLA_WR);
      resp_o    = (state_q == CLA_DONE);
      burst_o   = '0;
      if (state_q == CLA_WR) burst_o = wr_line[beat_lsb +: CLA_BURST_W];
      line_o    = rd_line;
      address_o = {addr_q[31:5], 5'b0};
      state_dbg = state_q;
   end

   // Fill buffer is only touched by RD beats, so line_o holds after DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         addr_q  <= '0;
         wr_line <= '0;
         rd_line <= '0;
      end else begin
         case (state_q)
            CLA_IDLE: begin
               cnt <= '0;
               if (write_i) begin
                  addr_q  <= address_i;
                  wr_line <= line_i;
               end else if (read_i) begin
                  addr_q  <= address_i;
               end
            end
            CLA_RD: begin
               if (resp_i) begin
                  rd_line[beat_lsb +: CLA_BURST_W] <= burst_i;
                  cnt <= cnt + 2'd1;
               end
            end
            CLA_WR: begin
               if (resp_i) cnt <= cnt + 2'd1;
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule
